// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 frame receiver with E0/F0 prefix handling and per-key held/press tracking.
// Define KB_PARITY_CHECK_EN to enforce odd parity; otherwise the parity bit is ignored.
module ps2_key_decoder #(
  parameter int NUM_KEYS = 5,
  parameter logic [8*NUM_KEYS-1:0] KEY_CODES = 40'h2B231B1C1D,
  parameter logic [NUM_KEYS-1:0] KEY_EXT = '0,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  output logic                code_valid,
  output logic [7:0]          code_data,
  output logic                code_ext,
  output logic                code_break,
  output logic                frame_err,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_press
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3;
  logic [1:0] clk_s, dat_s;
  logic clk_d, fe, dat;
  logic [1:0] state;
  logic [2:0] cnt;
  logic [7:0] sh;
  logic ext_pend, brk_pend, par_ok, byte_ok, timeout;
  logic [TW-1:0] wd;
`ifdef KB_PARITY_CHECK_EN
  logic par;
  assign par_ok = ^{sh, par};
  always_ff @(posedge clk or negedge rst)
    if (!rst) par <= 1'b0;
    else if (fe && state == PARITY) par <= dat;
`else
  assign par_ok = 1'b1;
`endif
  assign byte_ok = fe && state == STOP && dat && par_ok;
  // fe has priority over an expiring watchdog
  assign timeout = !fe && state != IDLE && wd == TW'(TIMEOUT_CYCLES);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      clk_s <= '0;
      dat_s <= '0;
      clk_d <= 1'b0;
      fe    <= 1'b0;
      dat   <= 1'b0;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_data};
      clk_d <= clk_s[1];
      fe    <= clk_d & ~clk_s[1];
      dat   <= dat_s[1];
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sh        <= '0;
      wd        <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (fe) wd <= '0;
      else if (state != IDLE && !timeout) wd <= wd + 1'b1;
      if (timeout) begin
        state     <= IDLE;
        frame_err <= 1'b1;
        wd        <= '0;
      end else if (fe)
        case (state)
          IDLE: if (!dat) begin
            state <= DATA;
            cnt   <= '0;
          end
          DATA: begin
            sh    <= {dat, sh[7:1]};
            cnt   <= cnt + 1'b1;
            state <= cnt == 3'd7 ? PARITY : DATA;
          end
          PARITY: state <= STOP;
          default: begin
            frame_err <= !(dat && par_ok);
            state     <= IDLE;
          end
        endcase
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
      code_valid <= 1'b0;
      code_data  <= '0;
      code_ext   <= 1'b0;
      code_break <= 1'b0;
      key_down   <= '0;
      key_press  <= '0;
    end else begin
      code_valid <= 1'b0;
      key_press  <= '0;
      if (timeout) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (byte_ok) begin
        if (sh == 8'hE0) ext_pend <= 1'b1;
        else if (sh == 8'hF0) brk_pend <= 1'b1;
        else begin
          code_valid <= 1'b1;
          code_data  <= sh;
          code_ext   <= ext_pend;
          code_break <= brk_pend;
          ext_pend   <= 1'b0;
          brk_pend   <= 1'b0;
          for (int i = 0; i < NUM_KEYS; i++)
            if (sh == KEY_CODES[8*i +: 8] && ext_pend == KEY_EXT[i]) begin
              key_down[i]  <= !brk_pend;
              key_press[i] <= !brk_pend && !key_down[i];
            end
        end
      end
    end
endmodule
